// File: rtl/leaf_bridge_pkg.sv
// Shared definitions for the leaf stream bridge: run-control state encoding and sizing helpers.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package leaf_bridge_pkg;

  // Run-control FSM states (ap_ctrl_hs handshake sequencing).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Ceiling log2, used to size FIFO pointers from the depth.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Default channel FIFO sizing; pointers carry one extra wrap bit for full/empty.
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DEFAULT_ADDR_BITS  = clog2(DEFAULT_FIFO_DEPTH);
  localparam int DEFAULT_PTR_BITS   = DEFAULT_ADDR_BITS + 1;

endpackage

// File: rtl/leaf_bridge_fifo.sv
// Per-channel synchronous FIFO with valid/ready on both sides, registered storage.
// Latency: a word written on edge N is presented after edge N (1 cycle), no bypass.
// Backpressure: wr_rdy_o = not full (held low in reset and until the first edge after release).
module leaf_bridge_fifo
  import leaf_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS = 32,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_vld_i,
  output logic                    wr_rdy_o,
  input  logic [PAYLOAD_BITS-1:0] wr_dat_i,
  output logic                    rd_vld_o,
  input  logic                    rd_rdy_i,
  output logic [PAYLOAD_BITS-1:0] rd_dat_o
);

  localparam int AW = clog2(FIFO_DEPTH);

  logic [AW:0]             wr_ptr_q, wr_ptr_d;
  logic [AW:0]             rd_ptr_q, rd_ptr_d;
  logic                    alive_q;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];

  // Same index with differing wrap bit means the writer lapped the reader.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  // alive_q keeps ready low through reset so every output reads 0 until the first edge after release.
  assign wr_rdy_o = alive_q & ~full;
  assign rd_vld_o = ~empty;
  assign rd_dat_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign push     = wr_vld_i & wr_rdy_o;
  assign pop      = rd_vld_o & rd_rdy_i;

  // Pointer advance on accepted push/pop; natural wrap through the extra bit.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  // Pointer and ready-enable registers; reset flushes the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      alive_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      alive_q  <= 1'b1;
    end
  end

  // Storage write; contents need no reset because the output is gated by empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end
  end

endmodule

// File: rtl/leaf_stream_bridge.sv
// Bridge between leaf_interface vld/ack streams and HLS AXI-stream ports with per-channel FIFOs, word counters and ap_ctrl_hs run control.
// Latency: 1 cycle through each channel FIFO; done pulses the cycle after DRAIN sees all output FIFOs empty.
// Backpressure: each side's ready is its FIFO's not-full; FIFOs move data regardless of FSM state.
module leaf_stream_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int NUM_IN_PORTS  = 2,
  parameter int NUM_OUT_PORTS = 2,
  parameter int PAYLOAD_BITS  = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_BITS      = 16
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    run_req,
  input  logic                                    auto_restart,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    ap_start,
  input  logic                                    ap_ready,
  input  logic                                    ap_done,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    if_dout,
  input  logic [NUM_IN_PORTS-1:0]                 if_vld,
  output logic [NUM_IN_PORTS-1:0]                 if_ack,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    usr_in_tdata,
  output logic [NUM_IN_PORTS-1:0]                 usr_in_tvalid,
  input  logic [NUM_IN_PORTS-1:0]                 usr_in_tready,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   usr_out_tdata,
  input  logic [NUM_OUT_PORTS-1:0]                usr_out_tvalid,
  output logic [NUM_OUT_PORTS-1:0]                usr_out_tready,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   if_din,
  output logic [NUM_OUT_PORTS-1:0]                if_vld_out,
  input  logic [NUM_OUT_PORTS-1:0]                if_ack_in,
  output logic [NUM_IN_PORTS*CNT_BITS-1:0]        in_cnt,
  output logic [NUM_OUT_PORTS*CNT_BITS-1:0]       out_cnt
);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   cnt_clr;
  logic   out_empty;

  // DRAIN may only finish once nothing is left for leaf_interface.
  assign out_empty = ~|if_vld_out;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  // Next-state and ap_start decode for the ap_ctrl_hs handshake.
  always_comb begin
    state_d  = state_q;
    ap_start = 1'b0;
    cnt_clr  = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_req) begin
          state_d = START;
          cnt_clr = 1'b1;
        end
      end
      START: begin
        ap_start = 1'b1;
        // ap_done is deliberately ignored here; it is only honoured in WAIT.
        if (ap_ready) state_d = WAIT;
      end
      WAIT: begin
        if (ap_done) state_d = auto_restart ? START : DRAIN;
      end
      DRAIN: begin
        if (out_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  for (genvar g = 0; g < NUM_IN_PORTS; g++) begin : g_in
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    leaf_bridge_fifo #(
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_vld_i (if_vld[g]),
      .wr_rdy_o (if_ack[g]),
      .wr_dat_i (if_dout[g*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld_o (usr_in_tvalid[g]),
      .rd_rdy_i (usr_in_tready[g]),
      .rd_dat_o (usr_in_tdata[g*PAYLOAD_BITS +: PAYLOAD_BITS])
    );

    // Count words delivered to the kernel; a new run restarts the count.
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) cnt_d = '0;
      else if (usr_in_tvalid[g] && usr_in_tready[g]) cnt_d = cnt_q + CNT_BITS'(1);
    end

    // Delivered-word counter register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign in_cnt[g*CNT_BITS +: CNT_BITS] = cnt_q;
  end

  for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_out
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    leaf_bridge_fifo #(
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_vld_i (usr_out_tvalid[g]),
      .wr_rdy_o (usr_out_tready[g]),
      .wr_dat_i (usr_out_tdata[g*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld_o (if_vld_out[g]),
      .rd_rdy_i (if_ack_in[g]),
      .rd_dat_o (if_din[g*PAYLOAD_BITS +: PAYLOAD_BITS])
    );

    // Count words accepted from the kernel; a new run restarts the count.
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) cnt_d = '0;
      else if (usr_out_tvalid[g] && usr_out_tready[g]) cnt_d = cnt_q + CNT_BITS'(1);
    end

    // Accepted-word counter register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign out_cnt[g*CNT_BITS +: CNT_BITS] = cnt_q;
  end

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Self-checking bench for leaf_stream_bridge: scoreboard queues filled by stimulus, drained by a negedge monitor.
// Latency: n/a.
// Backpressure: stimulus tasks wait (bounded) on ready before releasing valid.
module tb_leaf_stream_bridge;

  localparam int NI = 2;
  localparam int NO = 2;
  localparam int PB = 32;
  localparam int FD = 4;
  localparam int CB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              run_req, auto_restart, busy, done, ap_start, ap_ready, ap_done;
  logic [NI*PB-1:0]  if_dout, usr_in_tdata;
  logic [NI-1:0]     if_vld, if_ack, usr_in_tvalid, usr_in_tready;
  logic [NO*PB-1:0]  usr_out_tdata, if_din;
  logic [NO-1:0]     usr_out_tvalid, usr_out_tready, if_vld_out, if_ack_in;
  logic [NI*CB-1:0]  in_cnt;
  logic [NO*CB-1:0]  out_cnt;

  leaf_stream_bridge #(
    .NUM_IN_PORTS (NI), .NUM_OUT_PORTS (NO), .PAYLOAD_BITS (PB),
    .FIFO_DEPTH (FD), .CNT_BITS (CB)
  ) dut (
    .clk (clk), .reset_n (reset_n), .run_req (run_req), .auto_restart (auto_restart),
    .busy (busy), .done (done), .ap_start (ap_start), .ap_ready (ap_ready), .ap_done (ap_done),
    .if_dout (if_dout), .if_vld (if_vld), .if_ack (if_ack),
    .usr_in_tdata (usr_in_tdata), .usr_in_tvalid (usr_in_tvalid), .usr_in_tready (usr_in_tready),
    .usr_out_tdata (usr_out_tdata), .usr_out_tvalid (usr_out_tvalid), .usr_out_tready (usr_out_tready),
    .if_din (if_din), .if_vld_out (if_vld_out), .if_ack_in (if_ack_in),
    .in_cnt (in_cnt), .out_cnt (out_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int start_cyc = 0;
  int done_cnt  = 0;
  int idle_cyc  = 0;

  logic [31:0] q_in0[$];
  logic [31:0] q_in1[$];
  logic [31:0] q_out0[$];
  logic [31:0] q_out1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard pop and compare for one stream (0/1 = in ports, 2/3 = out ports).
  task automatic pop_cmp(input int sel, input logic [31:0] act);
    logic [31:0] e;
    bit ok;
    ok = 1'b0;
    e  = '0;
    case (sel)
      0: if (q_in0.size()  > 0) begin e = q_in0.pop_front();  ok = 1'b1; end
      1: if (q_in1.size()  > 0) begin e = q_in1.pop_front();  ok = 1'b1; end
      2: if (q_out0.size() > 0) begin e = q_out0.pop_front(); ok = 1'b1; end
      default: if (q_out1.size() > 0) begin e = q_out1.pop_front(); ok = 1'b1; end
    endcase
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL sb_stream%0d: got unexpected word %0h, expected none", sel, act);
    end else if (act !== e) begin
      n_fail++;
      $display("FAIL sb_stream%0d: got %0h, expected %0h", sel, act, e);
    end
  endtask

  // Monitor: sample away from the rising edge, compare every transfer against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (usr_in_tvalid[0] && usr_in_tready[0]) pop_cmp(0, usr_in_tdata[31:0]);
      if (usr_in_tvalid[1] && usr_in_tready[1]) pop_cmp(1, usr_in_tdata[63:32]);
      if (if_vld_out[0] && if_ack_in[0])        pop_cmp(2, if_din[31:0]);
      if (if_vld_out[1] && if_ack_in[1])        pop_cmp(3, if_din[63:32]);
      if (ap_start) start_cyc++;
      if (done)     done_cnt++;
      if (!busy)    idle_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send_in(input int k, input logic [31:0] d, output int stalls);
    int t;
    t = 0;
    if_dout[k*PB +: PB] = d;
    if_vld[k] = 1'b1;
    if (k == 0) q_in0.push_back(d); else q_in1.push_back(d);
    @(negedge clk);
    while (!if_ack[k] && t < 50) begin
      t++;
      @(negedge clk);
    end
    stalls = t;
    if (!if_ack[k]) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_in%0d_timeout: got ack 0, expected 1 within 50 cycles", k);
      if (k == 0) void'(q_in0.pop_back()); else void'(q_in1.pop_back());
    end
    @(posedge clk);
    #1;
    if_vld[k] = 1'b0;
  endtask

  task automatic send_out(input int k, input logic [31:0] d);
    int t;
    t = 0;
    usr_out_tdata[k*PB +: PB] = d;
    usr_out_tvalid[k] = 1'b1;
    if (k == 0) q_out0.push_back(d); else q_out1.push_back(d);
    @(negedge clk);
    while (!usr_out_tready[k] && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!usr_out_tready[k]) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_out%0d_timeout: got tready 0, expected 1 within 50 cycles", k);
      if (k == 0) void'(q_out0.pop_back()); else void'(q_out1.pop_back());
    end
    @(posedge clk);
    #1;
    usr_out_tvalid[k] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tvalid"},  {62'd0, usr_in_tvalid}, 64'd0);
    check({tag, "_vld_out"}, {62'd0, if_vld_out}, 64'd0);
    check({tag, "_readies"}, {60'd0, if_ack, usr_out_tready}, 64'd0);
    check({tag, "_ctrl"},    {61'd0, busy, done, ap_start}, 64'd0);
    check({tag, "_cnts"},    {48'd0, in_cnt, out_cnt}, 64'd0);
    check({tag, "_tdata"},   usr_in_tdata, 64'd0);
    check({tag, "_din"},     if_din, 64'd0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int tot;
    int s0;
    int d0;
    int i0;
    int t;

    reset_n = 1'b0;
    run_req = 1'b0; auto_restart = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
    if_dout = '0; if_vld = '0; usr_in_tready = '0;
    usr_out_tdata = '0; usr_out_tvalid = '0; if_ack_in = '0;

    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    ticks(2);
    check("post_rst_ack", {62'd0, if_ack}, 64'd3);
    check("post_rst_tready", {62'd0, usr_out_tready}, 64'd3);
    check("post_rst_busy", {63'd0, busy}, 64'd0);

    // T1: first-word latency and full backpressure on input port 0.
    send_in(0, 32'hA5A5_0001, st);
    check("t1_vld_latency", {63'd0, usr_in_tvalid[0]}, 64'd1);
    check("t1_head_data", {32'd0, usr_in_tdata[31:0]}, 64'hA5A5_0001);
    send_in(0, 32'hA5A5_0002, st);
    send_in(0, 32'hA5A5_0003, st);
    send_in(0, 32'hA5A5_0004, st);
    check("t1_full_ack", {63'd0, if_ack[0]}, 64'd0);
    tick();
    check("t1_full_ack_hold", {63'd0, if_ack[0]}, 64'd0);
    usr_in_tready[0] = 1'b1;
    ticks(6);
    check("t1_in_cnt0", {60'd0, in_cnt[3:0]}, 64'd4);

    // T2: streaming 10 words through port 1 with the kernel always ready.
    usr_in_tready[1] = 1'b1;
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      send_in(1, i, st);
      tot += st;
    end
    check("t2_ack_never_dropped", tot, 64'd0);
    ticks(3);
    check("t2_in_cnt1", {60'd0, in_cnt[7:4]}, 64'd10);

    // T3: single run, ap_ready on the 3rd START cycle, then drain and done.
    s0 = start_cyc;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    check("t3_start", {62'd0, ap_start, busy}, 64'd3);
    check("t3_cnt_clear", {56'd0, in_cnt}, 64'd0);
    ticks(2);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    check("t3_wait_start_low", {62'd0, ap_start, busy}, 64'd1);
    check("t3_start_cycles", start_cyc - s0, 64'd3);
    ticks(2);
    d0 = done_cnt;
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    check("t3_drain_busy", {62'd0, busy, done}, 64'd2);
    tick();
    check("t3_idle_done", {62'd0, busy, done}, 64'd1);
    tick();
    check("t3_done_low", {63'd0, done}, 64'd0);
    check("t3_done_pulses", done_cnt - d0, 64'd1);

    // T4: auto-restart keeps counters and never visits IDLE.
    auto_restart = 1'b1;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    i0 = idle_cyc;
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    send_in(0, 32'h0000_0100, st);
    send_in(0, 32'h0000_0101, st);
    if_ack_in[1] = 1'b1;
    send_out(1, 32'hBEEF_0001);
    ticks(3);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    check("t4_restart1", {62'd0, ap_start, busy}, 64'd3);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    check("t4_restart2", {62'd0, ap_start, busy}, 64'd3);
    check("t4_no_idle", idle_cyc - i0, 64'd0);
    check("t4_in_cnt0_kept", {60'd0, in_cnt[3:0]}, 64'd2);
    check("t4_out_cnt1_kept", {60'd0, out_cnt[7:4]}, 64'd1);
    auto_restart = 1'b0;
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    ticks(2);
    check("t4_back_idle", {63'd0, busy}, 64'd0);

    // T5: DRAIN holds while output FIFO 0 is blocked, then finishes.
    if_ack_in[0] = 1'b0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    send_out(0, 32'hC0DE_0001);
    send_out(0, 32'hC0DE_0002);
    send_out(0, 32'hC0DE_0003);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    ticks(5);
    check("t5_drain_hold", {62'd0, busy, if_vld_out[0]}, 64'd3);
    if_ack_in[0] = 1'b1;
    t = 0;
    while (!done && t < 20) begin
      tick();
      t++;
    end
    check("t5_done_seen", {63'd0, done}, 64'd1);
    check("t5_words_left", q_out0.size(), 64'd0);
    check("t5_out_cnt0", {60'd0, out_cnt[3:0]}, 64'd3);

    // T6: asynchronous reset mid-stream discards buffered words.
    usr_in_tready = '0;
    if_ack_in = '0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    send_in(0, 32'h0000_00D1, st);
    send_in(0, 32'h0000_00D2, st);
    send_out(1, 32'h0000_00E1);
    check("t6_pre_state", {60'd0, busy, usr_in_tvalid[0], if_vld_out[1], out_cnt[4]}, 64'hF);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    q_in0.delete();
    q_out1.delete();
    @(posedge clk); #2;
    reset_n = 1'b1;
    ticks(2);
    check("t6_post_empty", {60'd0, usr_in_tvalid, if_vld_out}, 64'd0);
    check("t6_post_idle", {63'd0, busy}, 64'd0);
    check("t6_post_cnts", {48'd0, in_cnt, out_cnt}, 64'd0);
    check("t6_post_ack", {62'd0, if_ack}, 64'd3);

    // T7: counter wrap with CNT_BITS=4 after 17 transfers.
    usr_in_tready[0] = 1'b1;
    for (int i = 0; i < 17; i++) send_in(0, 32'h7000 + i, st);
    ticks(3);
    check("t7_cnt_wrap", {60'd0, in_cnt[3:0]}, 64'd1);

    ticks(2);
    check("end_q_in0", q_in0.size(), 64'd0);
    check("end_q_in1", q_in1.size(), 64'd0);
    check("end_q_out0", q_out0.size(), 64'd0);
    check("end_q_out1", q_out1.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/leaf_stream_bridge.md
Name: leaf_stream_bridge

Overview:
- Parametrised bridge between the leaf_interface user side (vld/ack word streams) and an HLS kernel's AXI-stream ports (TDATA/TVALID/TREADY).
- Adds a per-channel FIFO on every input and output port, and per-port word counters.
- Adds an ap_ctrl_hs run-control FSM in place of a hardwired ap_start.
- Sits inside each leaf wrapper, between leaf_interface and the user kernel; channel counts and widths are generic.

Parameters:
- NUM_IN_PORTS, 2, number of interface-to-user channels (1..15).
- NUM_OUT_PORTS, 2, number of user-to-interface channels (1..15).
- PAYLOAD_BITS, 32, word width per channel.
- FIFO_DEPTH, 4, words per channel FIFO; power of two, >=2.
- CNT_BITS, 16, width of each per-port word counter.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- run_req  in  1  level; start the kernel when in IDLE.
- auto_restart  in  1  when 1, re-issue ap_start after each ap_done.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the DRAIN->IDLE transition.
- ap_start  out  1  to kernel.
- ap_ready  in  1  from kernel.
- ap_done  in  1  from kernel.
- if_dout  in  NUM_IN_PORTS*PAYLOAD_BITS  words from leaf_interface; port k occupies bits [k*PAYLOAD_BITS +: PAYLOAD_BITS].
- if_vld  in  NUM_IN_PORTS  valid from leaf_interface.
- if_ack  out  NUM_IN_PORTS  ready to leaf_interface.
- usr_in_tdata  out  NUM_IN_PORTS*PAYLOAD_BITS  kernel Input_k TDATA.
- usr_in_tvalid  out  NUM_IN_PORTS  kernel Input_k TVALID.
- usr_in_tready  in  NUM_IN_PORTS  kernel Input_k TREADY.
- usr_out_tdata  in  NUM_OUT_PORTS*PAYLOAD_BITS  kernel Output_k TDATA.
- usr_out_tvalid  in  NUM_OUT_PORTS  kernel Output_k TVALID.
- usr_out_tready  out  NUM_OUT_PORTS  kernel Output_k TREADY.
- if_din  out  NUM_OUT_PORTS*PAYLOAD_BITS  words to leaf_interface.
- if_vld_out  out  NUM_OUT_PORTS  valid to leaf_interface.
- if_ack_in  in  NUM_OUT_PORTS  ready from leaf_interface.
- in_cnt  out  NUM_IN_PORTS*CNT_BITS  words delivered to the kernel, per port.
- out_cnt  out  NUM_OUT_PORTS*CNT_BITS  words accepted from the kernel, per port.

Behaviour:
- Reset: async assert (reset_n=0) clears all state immediately; deassertion is used synchronously.
  - All outputs 0 during and after reset, including if_ack and usr_out_tready. The FIFO-ready defaults take effect in the first cycle after release.
  - FSM returns to IDLE, FIFOs flush, counters clear.
  - Reset mid-operation discards buffered words without emitting them.
- Transfer rule: a word moves when valid and ready are both high on a rising edge, on every channel.
- Channel FIFO, identical for input and output channels:
  - Upstream ready = not full.
  - Downstream valid = not empty; data = head word, registered storage.
  - Latency: a word written at edge N is visible at the output after edge N, i.e. first-word latency 1 cycle. There is no empty-FIFO bypass.
  - Push and pop in the same cycle: when neither full nor empty, occupancy is unchanged. When full, ready is low, so only the pop occurs.
  - Pointers are log2(FIFO_DEPTH) bits, wrap naturally, plus one extra bit for full/empty discrimination.
- FIFO data flow is independent of FSM state; FIFOs pass data even in IDLE.
- Counters:
  - in_cnt[k] increments on each usr_in transfer on port k; out_cnt[k] on each usr_out transfer.
  - Wrap modulo 2^CNT_BITS.
  - Cleared synchronously on the IDLE->START transition.
- FSM states: IDLE, START, WAIT, DRAIN.
  - IDLE: ap_start=0. If run_req=1, go to START.
  - START: ap_start=1. If ap_ready=1, go to WAIT; ap_start drops the next cycle. If ap_ready and ap_done are both 1 in the same cycle, go to WAIT anyway; ap_done is sampled only in WAIT.
  - WAIT: ap_start=0. If ap_done=1: with auto_restart=1 go to START, else go to DRAIN.
  - DRAIN: stay until all output FIFOs are empty, then go to IDLE and pulse done for one cycle.
  - run_req deasserting in START or WAIT has no effect; deasserting auto_restart takes effect at the next ap_done.

Decomposition:
- Package leaf_bridge_pkg holds:
  - the FSM state encoding (2-bit localparams IDLE=0, START=1, WAIT=2, DRAIN=3);
  - a clog2 helper function;
  - pointer-width localparams derived from FIFO_DEPTH.
- Sub-module leaf_bridge_fifo: one parametrised synchronous FIFO (PAYLOAD_BITS, FIFO_DEPTH) with valid/ready on both sides. The top instantiates it NUM_IN_PORTS + NUM_OUT_PORTS times with generate loops.

Test Plan:
- Reset release, then drive if_vld[0]=1 with data 0xA5A5_0001 while usr_in_tready=0 → usr_in_tvalid[0]=1 one cycle later. Accept exactly 4 words, then if_ack[0]=0.
- Hold usr_in_tready[1]=1 and stream 10 words 0..9 on port 1 → words appear in order, in_cnt[1]=10, if_ack[1] never drops.
- run_req=1, ap_ready=1 on the 3rd cycle of START → ap_start high exactly 3 cycles, busy=1. Pulse ap_done with auto_restart=0 → DRAIN, then IDLE and a one-cycle done pulse.
- auto_restart=1 with two ap_done pulses → ap_start reasserted twice with no pass through IDLE; in_cnt/out_cnt not cleared.
- In DRAIN with 3 words queued in output FIFO 0 and if_ack_in[0] held 0 for 5 cycles → FSM stays in DRAIN. Release ack → 3 words emitted, then done.
- Drive reset_n low mid-stream with FIFOs partly full, asynchronously between edges → outputs 0 immediately. After release, FIFOs empty, counters 0, FSM in IDLE.
- CNT_BITS=4: 17 transfers on port 0 → in_cnt[0]=1.
